ssp_tx_ctrl: RTL and testbench

SSP_TX_CTRL -- requirements
Module: ssp_tx_ctrl

---
 rtl/ssp_pkg.sv | 14 +
 rtl/ssp_clk_div.sv | 39 +++
 rtl/ssp_tx_ctrl.sv | 114 +++++++++++
 tb/tb_ssp_tx_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ssp_pkg.sv
// Shared defaults and FSM state encoding for the SSP transmit path.
package ssp_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int CLK_DIV_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FRAME = 2'd2,
    SHIFT = 2'd3
  } ssp_state_t;

endpackage

// File: rtl/ssp_clk_div.sv
// Serial bit-timing divider: half_tick ends each half-bit, bit_tick ends each bit.
// Combinational ticks from registered counters; counts only while en, restarted by restart/clear.
module ssp_clk_div
  import ssp_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic clear,
  input  logic restart,
  input  logic en,
  output logic half_tick,
  output logic bit_tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;
  // phase 0 is the high half of the serial clock, phase 1 the low half
  logic       phase;

  assign half_tick = en && (cnt == LAST);
  assign bit_tick  = half_tick && phase;

  always_ff @(posedge clk) begin
    if (clear || restart) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/ssp_tx_ctrl.sv
// SSP transmit controller (TI frame format): pops one FIFO word per frame, shifts it out MSB first.
// Start one cycle after SSE&TX_VALID; frame = 1 + 9*2*CLK_DIV cycles; back-to-back frames with no idle gap.
module ssp_tx_ctrl
  import ssp_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic              PCLK,
  input  logic              CLEAR,
  input  logic              SSE,
  input  logic              TX_VALID,
  input  logic [DATA_W-1:0] TxDATA,
  output logic              SENT,
  output logic              SSPCLKOUT,
  output logic              SSPFSSOUT,
  output logic              SSPTXD,
  output logic              SSPOE_B,
  output logic              BUSY
);

  localparam int BW = $clog2(DATA_W + 1);

  ssp_state_t        state;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic              half_tick;
  logic              bit_tick;
  logic              start;

  assign start = SSE && TX_VALID;

  ssp_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk       (PCLK),
    .clear     (CLEAR),
    .restart   (state == LOAD),
    .en        ((state == FRAME) || (state == SHIFT)),
    .half_tick (half_tick),
    .bit_tick  (bit_tick)
  );

  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      SENT      <= 1'b0;
      SSPCLKOUT <= 1'b0;
      SSPFSSOUT <= 1'b0;
      SSPTXD    <= 1'b0;
      SSPOE_B   <= 1'b1;
      BUSY      <= 1'b0;
    end else begin
      SENT <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            SENT  <= 1'b1;
            BUSY  <= 1'b1;
          end
        end
        LOAD: begin
          state     <= FRAME;
          shreg     <= TxDATA;
          SSPCLKOUT <= 1'b1;
          SSPFSSOUT <= 1'b1;
          SSPTXD    <= 1'b0;
          SSPOE_B   <= 1'b0;
        end
        FRAME: begin
          if (bit_tick) begin
            state     <= SHIFT;
            bit_cnt   <= BW'(DATA_W - 1);
            SSPTXD    <= shreg[DATA_W-1];
            shreg     <= shreg << 1;
            SSPFSSOUT <= 1'b0;
            SSPCLKOUT <= 1'b1;
          end else if (half_tick) begin
            SSPCLKOUT <= 1'b0;
          end
        end
        SHIFT: begin
          if (bit_tick) begin
            if (bit_cnt == '0) begin
              // end of bit 0: chain straight into the next word if one is ready
              SSPCLKOUT <= 1'b0;
              SSPTXD    <= 1'b0;
              SSPOE_B   <= 1'b1;
              if (start) begin
                state <= LOAD;
                SENT  <= 1'b1;
              end else begin
                state <= IDLE;
                BUSY  <= 1'b0;
              end
            end else begin
              bit_cnt   <= bit_cnt - 1'b1;
              SSPTXD    <= shreg[DATA_W-1];
              shreg     <= shreg << 1;
              SSPCLKOUT <= 1'b1;
            end
          end else if (half_tick) begin
            SSPCLKOUT <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ssp_tx_ctrl.sv
// Directed bench for ssp_tx_ctrl: FIFO model plus expected-word scoreboard, cycle-exact output checks.
module tb_ssp_tx_ctrl;

  logic       PCLK = 1'b0;
  logic       CLEAR = 1'b1;
  logic       SSE = 1'b0;
  logic       TX_VALID = 1'b0;
  logic [7:0] TxDATA = 8'h00;
  logic       txv1 = 1'b0;
  logic [7:0] txd1 = 8'h00;

  logic sent0, sclk0, fss0, txd0, oeb0, busy0;
  logic sent1, sclk1, fss1, txd1o, oeb1, busy1;

  int total = 0;
  int bad   = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  localparam logic [5:0] V_IDLE = 6'b000010;
  localparam logic [5:0] V_LOAD = 6'b100011;

  always #5 PCLK = ~PCLK;

  ssp_tx_ctrl #(.DATA_W(8), .CLK_DIV(2)) dut0 (
    .PCLK(PCLK), .CLEAR(CLEAR), .SSE(SSE), .TX_VALID(TX_VALID), .TxDATA(TxDATA),
    .SENT(sent0), .SSPCLKOUT(sclk0), .SSPFSSOUT(fss0), .SSPTXD(txd0),
    .SSPOE_B(oeb0), .BUSY(busy0)
  );

  ssp_tx_ctrl #(.DATA_W(8), .CLK_DIV(1)) dut1 (
    .PCLK(PCLK), .CLEAR(CLEAR), .SSE(SSE), .TX_VALID(txv1), .TxDATA(txd1),
    .SENT(sent1), .SSPCLKOUT(sclk1), .SSPFSSOUT(fss1), .SSPTXD(txd1o),
    .SSPOE_B(oeb1), .BUSY(busy1)
  );

  // {SENT, SSPCLKOUT, SSPFSSOUT, SSPTXD, SSPOE_B, BUSY}
  function automatic logic [5:0] obs(input int sel);
    if (sel == 0) return {sent0, sclk0, fss0, txd0, oeb0, busy0};
    return {sent1, sclk1, fss1, txd1o, oeb1, busy1};
  endfunction

  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] want);
    total++;
    assert (got === want)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, got, want);
    end
  endtask

  task automatic update_fifo();
    TX_VALID = (fifo_q.size() > 0);
    TxDATA   = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic push_word(input logic [7:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    update_fifo();
  endtask

  // The FIFO pop lands on the edge closing LOAD; changing the head half a cycle later is equivalent.
  task automatic pop(input int sel);
    if (sel == 0) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      update_fifo();
    end else begin
      txv1 = 1'b0;
    end
  endtask

  task automatic wait_sent(input int sel, input int max_cyc, input string tag);
    logic [5:0] v;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge PCLK);
      v = obs(sel);
      if (v[5]) ok = 1'b1;
    end
    total++;
    assert (ok)
    else begin
      bad++;
      $error("FAIL %s observed=no_sent expected=sent_within_%0d", tag, max_cyc);
    end
  endtask

  // Called at the negedge of the LOAD cycle; walks the whole frame cycle by cycle.
  task automatic check_frame(input int sel, input int cd, input int drop_at, input int clear_at);
    logic [7:0] w;
    logic [5:0] e;
    logic       b;
    int         per;
    w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    chk($sformatf("load_dut%0d_%h", sel, w), obs(sel), V_LOAD);
    for (int i = 0; i < 9 * 2 * cd; i++) begin
      @(negedge PCLK);
      if (i == 0) pop(sel);
      per = i / (2 * cd);
      b = 1'b0;
      if (per > 0) b = w[8-per];
      e = {1'b0, ((i % (2 * cd)) < cd), (per == 0), b, 1'b0, 1'b1};
      chk($sformatf("frame_dut%0d_%h_cyc%0d", sel, w, i), obs(sel), e);
      if (i == drop_at) SSE = 1'b0;
      if (i == clear_at) begin
        CLEAR = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    // reset held with a word pending and SSE high
    SSE  = 1'b1;
    push_word(8'hA5);
    txd1 = 8'h3C;
    txv1 = 1'b1;
    repeat (2) begin
      @(negedge PCLK);
      chk("reset_dut0", obs(0), V_IDLE);
      chk("reset_dut1", obs(1), V_IDLE);
    end
    SSE   = 1'b0;
    txv1  = 1'b0;
    CLEAR = 1'b0;
    @(negedge PCLK);
    chk("idle_sse_low", obs(0), V_IDLE);
    @(negedge PCLK);
    chk("idle_sse_low2", obs(0), V_IDLE);

    // single isolated word
    SSE = 1'b1;
    wait_sent(0, 1, "start_a5");
    check_frame(0, 2, -1, -1);
    @(negedge PCLK);
    chk("idle_after_a5", obs(0), V_IDLE);

    // back-to-back: three words queued at once
    push_word(8'h01);
    push_word(8'h02);
    push_word(8'h03);
    wait_sent(0, 1, "start_b2b");
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge PCLK);
      check_frame(0, 2, -1, -1);
    end
    @(negedge PCLK);
    chk("idle_after_b2b", obs(0), V_IDLE);

    // SSE dropped during bit 4 with another word still waiting
    push_word(8'hFF);
    push_word(8'hFF);
    wait_sent(0, 1, "start_ff");
    check_frame(0, 2, 17, -1);
    for (int k = 0; k < 4; k++) begin
      @(negedge PCLK);
      chk($sformatf("idle_after_sse_drop%0d", k), obs(0), V_IDLE);
    end
    fifo_q.delete();
    exp_q.delete();
    update_fifo();

    // CLEAR during bit 2
    SSE = 1'b1;
    push_word(8'h5A);
    wait_sent(0, 1, "start_5a");
    check_frame(0, 2, -1, 25);
    @(negedge PCLK);
    chk("midframe_clear", obs(0), V_IDLE);
    CLEAR = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge PCLK);
      chk($sformatf("idle_after_clear%0d", k), obs(0), V_IDLE);
    end

    // CLK_DIV=1 instance: 2-cycle bit period, 19-cycle frame
    exp_q.push_back(8'h3C);
    txd1 = 8'h3C;
    txv1 = 1'b1;
    wait_sent(1, 1, "start_div1");
    check_frame(1, 1, -1, -1);
    @(negedge PCLK);
    chk("idle_after_div1", obs(1), V_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
